// File: rtl/spi_wb_master_pkg.sv
// Shared definitions for the SPI-to-Wishbone bridge: FSM encoding, header
// layout and bus-side constants.
package spi_wb_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR_HI  = 3'd1,
    S_DATA_LO = 3'd2,
    S_DATA_HI = 3'd3,
    S_WB_WAIT = 3'd4
  } state_t;

  // byte0 = {addr[6:0], rnw}, byte1 = addr[14:7]
  localparam int HDR_RNW_BIT = 0;
  localparam int HDR_LO_BITS = 7;
  localparam int HDR_ADDR_W  = 15;

  localparam int          TIMEOUT_CYCLES_DEF = 64;
  localparam logic [7:0]  TX_IDLE            = 8'h00;
  localparam logic [1:0]  SEL_ALL            = 2'b11;

endpackage

// File: rtl/spi_wb_master_wb_cycle_timer.sv
// Watchdog for one Wishbone cycle: pulses o_expire once stb has been held for
// TIMEOUT_CYCLES clocks without an acknowledge.
module wb_cycle_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_stb,
  input  logic i_ack,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // Counter idles at zero while stb is low, so every new stb starts fresh.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn)               r_cnt <= '0;
    else if (!i_stb || i_ack) r_cnt <= '0;
    else if (!o_expire)       r_cnt <= r_cnt + CW'(1);
  end

  assign o_expire = i_stb && !i_ack && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/spi_wb_master.sv
// Wishbone initiator fed by the SPI slave byte stream: 2-byte header, then
// auto-incrementing 16-bit words; read data returned as tx bytes.
module spi_wb_master
  import spi_wb_master_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 15,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  frame_active,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic [7:0]            tx_data,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [1:0]            wb_sel_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  output logic                  bus_error
);

  state_t                  r_state, w_state_nxt;
  logic [HDR_ADDR_W-1:0]   r_addr;
  logic                    r_rnw;
  logic [7:0]              r_lo;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic [7:0]              r_tx;
  logic                    r_cyc, r_we, r_err, r_fa_d, r_lost;
  logic                    w_rx, w_start, w_done, w_expire, w_overrun, w_fa_rise;
  logic [DATA_WIDTH-1:0]   w_rd;

  wb_cycle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .i_stb    (r_cyc),
    .i_ack    (wb_ack_i),
    .o_expire (w_expire)
  );

  assign w_rx      = rx_valid && frame_active;
  assign w_done    = r_cyc && (wb_ack_i || w_expire);
  assign w_overrun = (r_state == S_WB_WAIT) && rx_valid;
  assign w_fa_rise = frame_active && !r_fa_d;
  assign w_rd      = wb_ack_i ? wb_dat_i : '0;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    unique case (r_state)
      S_IDLE:    if (w_rx) w_state_nxt = S_HDR_HI;
      S_HDR_HI:
        if (!frame_active) w_state_nxt = S_IDLE;
        else if (rx_valid) begin
          w_start     = r_rnw;
          w_state_nxt = r_rnw ? S_WB_WAIT : S_DATA_LO;
        end
      S_DATA_LO:
        if (!frame_active) w_state_nxt = S_IDLE;
        else if (rx_valid) w_state_nxt = S_DATA_HI;
      S_DATA_HI:
        if (!frame_active) w_state_nxt = S_IDLE;
        else if (rx_valid) begin
          w_start     = 1'b1;
          w_state_nxt = S_WB_WAIT;
        end
      // A frame that ended mid-cycle still lets the cycle finish, then idles.
      S_WB_WAIT:
        if (w_done) w_state_nxt = (r_lost || !frame_active) ? S_IDLE : S_DATA_LO;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_addr  <= '0;
      r_rnw   <= 1'b0;
      r_lo    <= '0;
      r_rdata <= '0;
      r_dat   <= '0;
      r_tx    <= TX_IDLE;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_fa_d  <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_fa_d <= frame_active;
      if (w_overrun || (w_done && w_expire)) r_err <= 1'b1;
      else if (w_fa_rise)                    r_err <= 1'b0;
      if (r_state == S_IDLE)  r_lost <= 1'b0;
      else if (!frame_active) r_lost <= 1'b1;

      unique case (r_state)
        S_IDLE: begin
          r_tx <= TX_IDLE;
          if (w_rx) begin
            r_addr <= {{(HDR_ADDR_W-HDR_LO_BITS){1'b0}}, rx_data[7:1]};
            r_rnw  <= rx_data[HDR_RNW_BIT];
          end
        end
        S_HDR_HI:  if (w_rx) r_addr[HDR_ADDR_W-1:HDR_LO_BITS] <= rx_data;
        S_DATA_LO:
          if (w_rx) begin
            if (r_rnw) r_tx <= r_rdata[15:8];
            else       r_lo <= rx_data;
          end
        S_DATA_HI: if (w_rx && !r_rnw) r_dat <= {rx_data, r_lo};
        S_WB_WAIT:
          if (w_done) begin
            r_addr <= r_addr + 1'b1;
            if (r_rnw) begin
              r_rdata <= w_rd;
              r_tx    <= w_rd[7:0];
            end
          end
        default: ;
      endcase

      if (w_start) begin
        r_cyc <= 1'b1;
        r_we  <= !r_rnw;
      end else if (w_done) begin
        r_cyc <= 1'b0;
        r_we  <= 1'b0;
      end
    end
  end

  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_cyc;
  assign wb_we_o   = r_we;
  assign wb_adr_o  = ADDR_WIDTH'(r_addr);
  assign wb_dat_o  = r_dat;
  assign wb_sel_o  = r_cyc ? SEL_ALL : 2'b00;
  assign tx_data   = r_tx;
  assign bus_error = r_err;

endmodule

// File: tb/tb_spi_wb_master.sv
// Directed bench for spi_wb_master with a single-cycle-ack BRAM model.
module tb_spi_wb_master;

  logic        clk = 1'b0, resetn = 1'b1, frame_active = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00, tx_data;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, bus_error;
  logic [14:0] wb_adr_o;
  logic [15:0] wb_dat_o, wb_dat_i;
  logic [1:0]  wb_sel_o;

  logic        r_ack  = 1'b0;
  logic        ack_en = 1'b1;
  logic [15:0] mem [16];
  logic [14:0] q_adr [$];
  logic        q_we  [$];
  logic [15:0] q_dat [$];
  int          n_tests = 0, n_fail = 0;

  spi_wb_master dut (
    .clk(clk), .resetn(resetn), .frame_active(frame_active), .rx_valid(rx_valid),
    .rx_data(rx_data), .tx_data(tx_data), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  assign wb_ack_i = r_ack;
  assign wb_dat_i = mem[wb_adr_o[3:0]];

  always @(posedge clk) begin
    r_ack <= wb_stb_o & ~r_ack & ack_en;
    if (wb_cyc_o && wb_stb_o && r_ack) begin
      q_adr.push_back(wb_adr_o);
      q_we.push_back(wb_we_o);
      q_dat.push_back(wb_dat_o);
      if (wb_we_o) mem[wb_adr_o[3:0]] <= wb_dat_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    pulse(b);
    gap(6);
  endtask

  task automatic clr_log();
    q_adr.delete();
    q_we.delete();
    q_dat.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_tx [4];
    int cnt;
    exp_tx = '{8'hAA, 8'hAA, 8'hBB, 8'hBB};
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[0] = 16'hAAAA; mem[1] = 16'hBBBB; mem[2] = 16'hCCCC;

    gap(3);
    resetn = 1'b0;
    gap(1);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 0);
    chk("rst_stb", {31'd0, wb_stb_o}, 0);
    chk("rst_we",  {31'd0, wb_we_o}, 0);
    chk("rst_sel", {30'd0, wb_sel_o}, 0);
    chk("rst_adr", {17'd0, wb_adr_o}, 0);
    chk("rst_dat", {16'd0, wb_dat_o}, 0);
    chk("rst_tx",  {24'd0, tx_data}, 0);
    chk("rst_err", {31'd0, bus_error}, 0);

    // Write one word at 0x0006
    clr_log();
    frame_active = 1'b1; gap(2);
    send(8'h0C); send(8'h00); send(8'h34);
    pulse(8'h12);
    chk("wr_cyc_live", {31'd0, wb_cyc_o}, 1);
    chk("wr_sel_live", {30'd0, wb_sel_o}, 3);
    chk("wr_tx_live",  {24'd0, tx_data}, 0);
    gap(6);
    frame_active = 1'b0; gap(4);
    chk("wr_ncyc", q_adr.size(), 1);
    if (q_adr.size() >= 1) begin
      chk("wr_adr", {17'd0, q_adr[0]}, 32'h6);
      chk("wr_we",  {31'd0, q_we[0]}, 1);
      chk("wr_dat", {16'd0, q_dat[0]}, 32'h1234);
    end
    chk("wr_mem", {16'd0, mem[6]}, 32'h1234);
    chk("wr_err", {31'd0, bus_error}, 0);

    // Read from 0: tx sequence AA,AA,BB,BB
    clr_log();
    frame_active = 1'b1; gap(2);
    send(8'h01);
    pulse(8'h00);
    chk("rd_cyc_n1", {31'd0, wb_cyc_o}, 1);
    chk("rd_we_n1",  {31'd0, wb_we_o}, 0);
    chk("rd_adr_n1", {17'd0, wb_adr_o}, 0);
    gap(1);
    chk("rd_tx_n2",  {24'd0, tx_data}, 0);
    gap(1);
    chk("rd_cyc_n3", {31'd0, wb_cyc_o}, 0);
    chk("rd_tx_n3",  {24'd0, tx_data}, 32'hAA);
    gap(4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd_tx%0d", i), {24'd0, tx_data}, {24'd0, exp_tx[i]});
      send(8'hFF);
    end
    frame_active = 1'b0; gap(4);
    chk("rd_ncyc", q_adr.size(), 3);
    for (int i = 0; i < 3 && i < q_adr.size(); i++)
      chk($sformatf("rd_adr%0d", i), {17'd0, q_adr[i]}, i);
    chk("rd_tx_idle", {24'd0, tx_data}, 0);

    // Write 2 words at 0x7FFF: address wraps to 0
    clr_log();
    frame_active = 1'b1; gap(2);
    send(8'hFE); send(8'hFF); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    frame_active = 1'b0; gap(4);
    chk("wrap_ncyc", q_adr.size(), 2);
    if (q_adr.size() >= 2) begin
      chk("wrap_adr0", {17'd0, q_adr[0]}, 32'h7FFF);
      chk("wrap_adr1", {17'd0, q_adr[1]}, 32'h0000);
      chk("wrap_dat0", {16'd0, q_dat[0]}, 32'h2211);
      chk("wrap_dat1", {16'd0, q_dat[1]}, 32'h4433);
    end

    // Timeout: no ack, stb held exactly 64 cycles
    clr_log();
    ack_en = 1'b0;
    frame_active = 1'b1; gap(2);
    send(8'h01);
    pulse(8'h00);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!wb_stb_o) break;
      cnt++;
      @(negedge clk);
    end
    chk("to_stb_cycles", cnt, 64);
    chk("to_cyc", {31'd0, wb_cyc_o}, 0);
    chk("to_err", {31'd0, bus_error}, 1);
    chk("to_tx",  {24'd0, tx_data}, 0);
    frame_active = 1'b0; gap(3);
    chk("to_err_sticky", {31'd0, bus_error}, 1);
    frame_active = 1'b1; gap(1);
    chk("to_err_clear", {31'd0, bus_error}, 0);

    // Overrun: byte during an outstanding cycle
    send(8'h01);
    pulse(8'h00);
    gap(3);
    chk("ovr_err_pre", {31'd0, bus_error}, 0);
    pulse(8'h99);
    chk("ovr_err", {31'd0, bus_error}, 1);
    chk("ovr_stb", {31'd0, wb_stb_o}, 1);
    ack_en = 1'b1; gap(4);
    chk("ovr_ncyc", q_adr.size(), 1);
    frame_active = 1'b0; gap(4);

    // Abort after one data byte, then a clean write proves return to idle
    clr_log();
    frame_active = 1'b1; gap(2);
    send(8'h0C); send(8'h00); send(8'h55);
    frame_active = 1'b0; gap(4);
    chk("abort_ncyc", q_adr.size(), 0);
    frame_active = 1'b1; gap(2);
    chk("abort_err_clear", {31'd0, bus_error}, 0);
    send(8'h10); send(8'h00); send(8'h78); send(8'h56);
    frame_active = 1'b0; gap(4);
    chk("abort_next_ncyc", q_adr.size(), 1);
    if (q_adr.size() >= 1) begin
      chk("abort_next_adr", {17'd0, q_adr[0]}, 32'h8);
      chk("abort_next_dat", {16'd0, q_dat[0]}, 32'h5678);
    end

    // Async reset during stb
    ack_en = 1'b0;
    frame_active = 1'b1; gap(2);
    send(8'h01);
    pulse(8'h00);
    gap(3);
    chk("rst2_stb_pre", {31'd0, wb_stb_o}, 1);
    resetn = 1'b1;
    #1;
    chk("rst2_cyc", {31'd0, wb_cyc_o}, 0);
    chk("rst2_stb", {31'd0, wb_stb_o}, 0);
    chk("rst2_sel", {30'd0, wb_sel_o}, 0);
    chk("rst2_adr", {17'd0, wb_adr_o}, 0);
    chk("rst2_tx",  {24'd0, tx_data}, 0);
    chk("rst2_err", {31'd0, bus_error}, 0);
    gap(2);
    frame_active = 1'b0;
    resetn = 1'b0;
    ack_en = 1'b1;
    gap(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
